// File: rtl/rv32i_pkg.sv
// rv32i_pkg: shared RV32I ALU control encodings and register-address helpers
package rv32i_pkg;
    localparam int XLEN   = 32;
    localparam int REG_AW = 5;
    localparam logic [REG_AW-1:0] REG_X0 = 5'd0;
    typedef enum logic [1:0] {
        ALU_ADD   = 2'b00,
        ALU_GATE  = 2'b01,
        ALU_SHIFT = 2'b10,
        ALU_SLT   = 2'b11
    } alu_type_e;
    // cu_alu packing, MSB first: {ALUtype[7:6], adtype[5], gatype[4:3], shiftype[2:1], sltype[0]}
    typedef struct packed {
        alu_type_e  alu_type;
        logic       adtype;
        logic [1:0] gatype;
        logic [1:0] shiftype;
        logic       sltype;
    } cu_alu_t;
    // a writer of rd produces a value that a reader of src needs (x0 never matches)
    function automatic logic rd_hit(input logic [REG_AW-1:0] src, input logic [REG_AW-1:0] rd, input logic we);
        return we && rd != REG_X0 && rd == src;
    endfunction
    // either used source of an instruction reads the register written by rd/we
    function automatic logic raw_hit(input logic [REG_AW-1:0] rd, input logic we,
                                     input logic use1, input logic [REG_AW-1:0] rs1,
                                     input logic use2, input logic [REG_AW-1:0] rs2);
        return (use1 && rd_hit(rs1, rd, we)) || (use2 && rd_hit(rs2, rd, we));
    endfunction
endpackage

// File: rtl/fwd_mux_rv32i.sv
// fwd_mux_rv32i: per-source operand bypass, MEM result beats WB result beats registered regfile data
module fwd_mux_rv32i
    import rv32i_pkg::*;
(
    input  logic [REG_AW-1:0] src,
    input  logic [XLEN-1:0]   reg_data,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic              mem_reg_write,
    input  logic [XLEN-1:0]   mem_result,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic              wb_reg_write,
    input  logic [XLEN-1:0]   wb_result,
    output logic [XLEN-1:0]   fwd
);
    assign fwd = rd_hit(src, mem_rd, mem_reg_write) ? mem_result :
                 rd_hit(src, wb_rd, wb_reg_write)   ? wb_result  : reg_data;
endmodule

// File: rtl/idex_operand_rv32i.sv
// idex_operand_rv32i: ID/EX register and ALU operand stage; IDEX_FORWARDING_EN enables MEM/WB bypass (else full RAW interlock)
module idex_operand_rv32i
    import rv32i_pkg::*;
(
    input  logic              clock,
    input  logic              rstn,
    input  logic              id_valid,
    output logic              id_ready,
    input  logic              ex_stall,
    input  logic              ex_flush,
    input  logic [XLEN-1:0]   id_pc,
    input  logic [XLEN-1:0]   id_imm,
    input  logic [XLEN-1:0]   id_rs1_data,
    input  logic [XLEN-1:0]   id_rs2_data,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_use1,
    input  logic              id_use2,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              id_alu1src,
    input  logic              id_alu2src,
    input  logic [7:0]        id_cu_alu,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic              mem_reg_write,
    input  logic              wb_reg_write,
    input  logic [XLEN-1:0]   mem_result,
    input  logic [XLEN-1:0]   wb_result,
    output logic [XLEN-1:0]   alu_in1,
    output logic [XLEN-1:0]   alu_in2,
    output logic [7:0]        ex_cu_alu,
    output logic [XLEN-1:0]   ex_store_data,
    output logic              ex_valid,
    output logic [REG_AW-1:0] ex_rd,
    output logic              ex_reg_write,
    output logic              ex_mem_read
);
    logic [XLEN-1:0]   ex_pc, ex_imm, ex_rs1_data, ex_rs2_data, fwd1, fwd2;
    logic [REG_AW-1:0] ex_rs1, ex_rs2;
    logic              ex_alu1src, ex_alu2src, hazard, bubble, fwd_mem_we, fwd_wb_we;
    cu_alu_t           ex_cu;

`ifdef IDEX_FORWARDING_EN
    // only a load in EX cannot be bypassed: its data arrives a cycle too late
    assign hazard     = id_valid && raw_hit(ex_rd, ex_valid && ex_mem_read, id_use1, id_rs1, id_use2, id_rs2);
    assign fwd_mem_we = mem_reg_write;
    assign fwd_wb_we  = wb_reg_write;
`else
    // without bypass, any in-flight writer of a source blocks ID until it has left WB
    assign hazard     = id_valid && (raw_hit(ex_rd, ex_valid && ex_reg_write, id_use1, id_rs1, id_use2, id_rs2) ||
                                     raw_hit(mem_rd, mem_reg_write, id_use1, id_rs1, id_use2, id_rs2) ||
                                     raw_hit(wb_rd, wb_reg_write, id_use1, id_rs1, id_use2, id_rs2));
    assign fwd_mem_we = 1'b0;
    assign fwd_wb_we  = 1'b0;
`endif

    assign id_ready = !ex_stall && !hazard;
    assign bubble   = ex_flush || (!ex_stall && hazard);

    fwd_mux_rv32i u_fwd1 (
        .src(ex_rs1), .reg_data(ex_rs1_data),
        .mem_rd(mem_rd), .mem_reg_write(fwd_mem_we), .mem_result(mem_result),
        .wb_rd(wb_rd), .wb_reg_write(fwd_wb_we), .wb_result(wb_result),
        .fwd(fwd1)
    );

    fwd_mux_rv32i u_fwd2 (
        .src(ex_rs2), .reg_data(ex_rs2_data),
        .mem_rd(mem_rd), .mem_reg_write(fwd_mem_we), .mem_result(mem_result),
        .wb_rd(wb_rd), .wb_reg_write(fwd_wb_we), .wb_result(wb_result),
        .fwd(fwd2)
    );

    assign alu_in1       = ex_alu1src ? ex_pc : fwd1;
    assign alu_in2       = ex_alu2src ? ex_imm : fwd2;
    assign ex_store_data = fwd2;
    assign ex_cu_alu     = ex_cu;

    // pipeline register: flush/bubble > stall (with WB refresh of held operands) > load from ID
    always_ff @(posedge clock or negedge rstn) begin
        if (!rstn) begin
            ex_valid     <= 1'b0;
            ex_reg_write <= 1'b0;
            ex_mem_read  <= 1'b0;
            ex_rd        <= '0;
            ex_rs1       <= '0;
            ex_rs2       <= '0;
            ex_pc        <= '0;
            ex_imm       <= '0;
            ex_rs1_data  <= '0;
            ex_rs2_data  <= '0;
            ex_alu1src   <= 1'b0;
            ex_alu2src   <= 1'b0;
            ex_cu        <= '{alu_type: ALU_ADD, default: '0};
        end else if (bubble) begin
            ex_valid     <= 1'b0;
            ex_reg_write <= 1'b0;
            ex_mem_read  <= 1'b0;
        end else if (ex_stall) begin
            if (rd_hit(ex_rs1, wb_rd, wb_reg_write)) ex_rs1_data <= wb_result;
            if (rd_hit(ex_rs2, wb_rd, wb_reg_write)) ex_rs2_data <= wb_result;
        end else begin
            ex_valid     <= id_valid;
            ex_reg_write <= id_valid && id_reg_write;
            ex_mem_read  <= id_valid && id_mem_read;
            ex_rd        <= id_rd;
            ex_rs1       <= id_rs1;
            ex_rs2       <= id_rs2;
            ex_pc        <= id_pc;
            ex_imm       <= id_imm;
            ex_rs1_data  <= id_rs1_data;
            ex_rs2_data  <= id_rs2_data;
            ex_alu1src   <= id_alu1src;
            ex_alu2src   <= id_alu2src;
            ex_cu        <= cu_alu_t'(id_cu_alu);
        end
    end
endmodule

// File: tb/tb_idex_operand_rv32i.sv
// tb_idex_operand_rv32i: directed bench with a per-cycle reference model of the ID/EX operand stage
module tb_idex_operand_rv32i;
`ifdef IDEX_FORWARDING_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic clock = 1'b0;
    logic rstn;
    logic id_valid, id_ready, ex_stall, ex_flush;
    logic [31:0] id_pc, id_imm, id_rs1_data, id_rs2_data;
    logic [4:0] id_rs1, id_rs2, id_rd, mem_rd, wb_rd;
    logic id_use1, id_use2, id_reg_write, id_mem_read, id_alu1src, id_alu2src;
    logic [7:0] id_cu_alu, ex_cu_alu;
    logic mem_reg_write, wb_reg_write;
    logic [31:0] mem_result, wb_result, alu_in1, alu_in2, ex_store_data;
    logic ex_valid, ex_reg_write, ex_mem_read;
    logic [4:0] ex_rd;

    always #5 clock = ~clock;

    idex_operand_rv32i dut (
        .clock(clock), .rstn(rstn), .id_valid(id_valid), .id_ready(id_ready),
        .ex_stall(ex_stall), .ex_flush(ex_flush), .id_pc(id_pc), .id_imm(id_imm),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rd(id_rd), .id_use1(id_use1), .id_use2(id_use2), .id_reg_write(id_reg_write),
        .id_mem_read(id_mem_read), .id_alu1src(id_alu1src), .id_alu2src(id_alu2src),
        .id_cu_alu(id_cu_alu), .mem_rd(mem_rd), .wb_rd(wb_rd), .mem_reg_write(mem_reg_write),
        .wb_reg_write(wb_reg_write), .mem_result(mem_result), .wb_result(wb_result),
        .alu_in1(alu_in1), .alu_in2(alu_in2), .ex_cu_alu(ex_cu_alu), .ex_store_data(ex_store_data),
        .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read)
    );

    // the instruction the model believes is sitting in EX; dc marks data left undefined by a bubble
    typedef struct packed {
        logic v, rw, mr, a1, a2, dc;
        logic [31:0] pc, imm, d1, d2;
        logic [4:0] rs1, rs2, rd;
        logic [7:0] cu;
    } ex_t;
    ex_t m;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic reads(input logic [4:0] r);
        return r != 5'd0 && ((id_use1 && id_rs1 == r) || (id_use2 && id_rs2 == r));
    endfunction

    function automatic logic m_hazard();
        if (!id_valid) return 1'b0;
        if (FWD) return m.v && m.mr && reads(m.rd);
        return (m.v && m.rw && reads(m.rd)) || (mem_reg_write && reads(mem_rd)) || (wb_reg_write && reads(wb_rd));
    endfunction

    function automatic logic [31:0] m_fwd(input logic [4:0] s, input logic [31:0] r);
        if (!FWD || s == 5'd0) return r;
        if (mem_reg_write && mem_rd == s) return mem_result;
        if (wb_reg_write && wb_rd == s) return wb_result;
        return r;
    endfunction

    always @(posedge clock or negedge rstn) begin
        if (!rstn) m <= '0;
        else if (ex_flush || (!ex_stall && m_hazard())) begin
            m.v <= 1'b0; m.rw <= 1'b0; m.mr <= 1'b0; m.dc <= 1'b1;
        end else if (ex_stall) begin
            if (wb_reg_write && wb_rd != 5'd0 && wb_rd == m.rs1) m.d1 <= wb_result;
            if (wb_reg_write && wb_rd != 5'd0 && wb_rd == m.rs2) m.d2 <= wb_result;
        end else
            m <= '{v: id_valid, rw: id_valid && id_reg_write, mr: id_valid && id_mem_read,
                   a1: id_alu1src, a2: id_alu2src, dc: 1'b0, pc: id_pc, imm: id_imm,
                   d1: id_rs1_data, d2: id_rs2_data, rs1: id_rs1, rs2: id_rs2, rd: id_rd, cu: id_cu_alu};
    end

    always @(negedge clock) begin
        chk("id_ready", id_ready, !ex_stall && !m_hazard());
        chk("ex_valid", ex_valid, m.v);
        chk("ex_reg_write", ex_reg_write, m.rw);
        chk("ex_mem_read", ex_mem_read, m.mr);
        if (!m.dc) begin
            chk("ex_rd", ex_rd, m.rd);
            chk("ex_cu_alu", ex_cu_alu, m.cu);
            chk("alu_in1", alu_in1, m.a1 ? m.pc : m_fwd(m.rs1, m.d1));
            chk("alu_in2", alu_in2, m.a2 ? m.imm : m_fwd(m.rs2, m.d2));
            chk("ex_store_data", ex_store_data, m_fwd(m.rs2, m.d2));
        end
    end

    task automatic idle();
        id_valid = 0; ex_stall = 0; ex_flush = 0;
        id_pc = 0; id_imm = 0; id_rs1_data = 0; id_rs2_data = 0;
        id_rs1 = 0; id_rs2 = 0; id_rd = 0; id_use1 = 0; id_use2 = 0;
        id_reg_write = 0; id_mem_read = 0; id_alu1src = 0; id_alu2src = 0; id_cu_alu = 0;
        mem_rd = 0; wb_rd = 0; mem_reg_write = 0; wb_reg_write = 0; mem_result = 0; wb_result = 0;
    endtask

    task automatic issue(input logic [31:0] pc, imm, d1, d2, input logic [4:0] rs1, rs2, rd,
                         input logic u1, u2, rw, mr, a1, a2, input logic [7:0] cu);
        id_valid = 1; id_pc = pc; id_imm = imm; id_rs1_data = d1; id_rs2_data = d2;
        id_rs1 = rs1; id_rs2 = rs2; id_rd = rd; id_use1 = u1; id_use2 = u2;
        id_reg_write = rw; id_mem_read = mr; id_alu1src = a1; id_alu2src = a2; id_cu_alu = cu;
    endtask

    task automatic tick();
        @(negedge clock);
        #2;
    endtask

    // producer position: age 1 = MEM, 2 = WB, 3+ = retired into the regfile read by ID
    task automatic stage(input int age, input logic [4:0] rd, input logic [31:0] val);
        mem_reg_write = (age == 1); mem_rd = (age == 1) ? rd : 5'd0; mem_result = val;
        wb_reg_write = (age == 2); wb_rd = (age == 2) ? rd : 5'd0; wb_result = val;
        id_rs1_data = (age >= 3) ? val : 32'h0;
    endtask

    // ID holds a consumer of rd while its producer has just entered EX
    task automatic dep_run(input string nm, input logic [4:0] rd, input logic [4:0] crd,
                           input logic [31:0] val, input int exp_bub);
        int age;
        int bub;
        age = 0; bub = 0;
        stage(age, rd, val);
        #1;
        while (!id_ready && bub < 8) begin
            bub++;
            tick();
            age++;
            stage(age, rd, val);
            #1;
        end
        chk({nm, " bubbles"}, bub, exp_bub);
        tick();
        age++;
        id_valid = 0;
        stage(age, rd, val);
        #1;
        chk({nm, " alu_in1"}, alu_in1, val);
        chk({nm, " ex_valid"}, ex_valid, 1'b1);
        chk({nm, " ex_rd"}, ex_rd, crd);
    endtask

    initial begin
        rstn = 0;
        idle();
        tick(); tick();
        chk("reset ex_valid", ex_valid, 1'b0);
        chk("reset ex_cu_alu", ex_cu_alu, 8'h00);
        chk("reset alu_in1", alu_in1, 32'h0);
        chk("reset alu_in2", alu_in2, 32'h0);
        rstn = 1;

        issue(32'h100, 32'h10, 32'h55, 32'h0, 5'd5, 5'd0, 5'd9, 1, 0, 1, 0, 0, 1, 8'h80);
        tick();
        chk("load ex_valid", ex_valid, 1'b1);
        chk("load ex_rd", ex_rd, 5'd9);
        chk("load alu_in2 imm", alu_in2, 32'h10);
        chk("load ex_cu_alu", ex_cu_alu, 8'h80);
        idle();
        mem_rd = 5; mem_reg_write = 1; mem_result = 32'hAAAA;
        wb_rd = 5; wb_reg_write = 1; wb_result = 32'hBBBB;
        #1;
        chk("fwd mem priority", alu_in1, FWD ? 32'hAAAA : 32'h55);
        mem_reg_write = 0;
        #1;
        chk("fwd wb", alu_in1, FWD ? 32'hBBBB : 32'h55);

        idle();
        issue(32'h200, 32'h0, 32'h3, 32'h0, 5'd1, 5'd0, 5'd12, 1, 1, 1, 0, 1, 0, 8'h21);
        mem_rd = 0; mem_reg_write = 1; mem_result = 32'h7;
        tick();
        chk("x0 alu_in2", alu_in2, 32'h0);
        chk("x0 store", ex_store_data, 32'h0);
        chk("x0 alu_in1 pc", alu_in1, 32'h200);

        idle();
        issue(32'h300, 32'h4, 32'h1000, 32'h0, 5'd2, 5'd0, 5'd3, 1, 0, 1, 1, 0, 1, 8'h00);
        tick();
        chk("lw ex_mem_read", ex_mem_read, 1'b1);
        issue(32'h304, 32'h0, 32'h0, 32'h11, 5'd3, 5'd1, 5'd4, 1, 1, 1, 0, 0, 0, 8'h00);
        dep_run("load-use", 5'd3, 5'd4, 32'hDEAD, FWD ? 1 : 3);

        idle();
        issue(32'h400, 32'h0, 32'h1, 32'h2, 5'd1, 5'd2, 5'd7, 1, 1, 1, 0, 0, 0, 8'h00);
        tick();
        issue(32'h404, 32'h5, 32'h0, 32'h0, 5'd7, 5'd0, 5'd10, 1, 0, 1, 0, 0, 1, 8'h00);
        dep_run("add-add", 5'd7, 5'd10, 32'h77, FWD ? 0 : 3);

        idle();
        issue(32'h500, 32'h0, 32'h66, 32'h99, 5'd6, 5'd8, 5'd8, 1, 1, 1, 0, 0, 0, 8'h5A);
        tick();
        issue(32'h600, 32'h0, 32'h1, 32'h2, 5'd1, 5'd2, 5'd11, 1, 1, 1, 0, 0, 0, 8'h33);
        ex_stall = 1;
        tick();
        wb_rd = 6; wb_reg_write = 1; wb_result = 32'h1234;
        tick();
        wb_rd = 0; wb_reg_write = 0; wb_result = 0;
        tick();
        ex_stall = 0;
        #1;
        chk("stall alu_in1", alu_in1, 32'h1234);
        chk("stall alu_in2", alu_in2, 32'h99);
        chk("stall ex_rd", ex_rd, 5'd8);
        chk("stall ex_cu_alu", ex_cu_alu, 8'h5A);
        chk("stall ex_valid", ex_valid, 1'b1);
        tick();
        chk("after stall ex_rd", ex_rd, 5'd11);

        idle();
        ex_flush = 1; ex_stall = 1;
        tick();
        chk("flush+stall ex_valid", ex_valid, 1'b0);
        chk("flush+stall ex_reg_write", ex_reg_write, 1'b0);

        idle();
        issue(32'h700, 32'hFFFF, 32'h1, 32'h2, 5'd1, 5'd2, 5'd13, 1, 1, 1, 1, 1, 1, 8'hFF);
        tick();
        chk("pre-reset ex_valid", ex_valid, 1'b1);
        rstn = 0;
        #1;
        chk("async reset ex_valid", ex_valid, 1'b0);
        chk("async reset ex_cu_alu", ex_cu_alu, 8'h00);
        chk("async reset alu_in1", alu_in1, 32'h0);
        chk("async reset alu_in2", alu_in2, 32'h0);
        chk("async reset ex_mem_read", ex_mem_read, 1'b0);
        tick(); tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
